// File: rtl/tmr_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tmr_fault_monitor
// Brief    : Registered fault classifier/logger behind a bank of per-bit TMR
//            majority voters. Identifies the disagreeing replica(s), keeps
//            saturating per-replica error counters, raises sticky alarm,
//            multi and overflow flags, and publishes a one-entry valid/ready
//            event record.
//            Optional feature macro: TMR_FAULT_MON_BITIDX_EN (adds the
//            lowest-faulty-bit priority encoder to the event record).
// Revision : 1.0 - initial release
// ============================================================================
module tmr_fault_monitor #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int THRESHOLD  = 4
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              valid_i,
    input  logic [DATA_WIDTH-1:0]                             a_i,
    input  logic [DATA_WIDTH-1:0]                             b_i,
    input  logic [DATA_WIDTH-1:0]                             c_i,
    input  logic [DATA_WIDTH-1:0]                             majority_i,
    input  logic [DATA_WIDTH-1:0]                             fault_i,
    input  logic                                              clr_i,
    output logic                                              evt_valid_o,
    input  logic                                              evt_ready_i,
    output logic [2:0]                                        evt_mask_o,
    output logic                                              evt_multi_o,
    output logic [((DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1)-1:0] evt_bit_o,
    output logic [CNT_WIDTH-1:0]                              cnt_a_o,
    output logic [CNT_WIDTH-1:0]                              cnt_b_o,
    output logic [CNT_WIDTH-1:0]                              cnt_c_o,
    output logic                                              alarm_o,
    output logic                                              multi_o,
    output logic                                              overflow_o
);

    localparam int                   c_BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_THRESH  = CNT_WIDTH'(THRESHOLD);

    // Increment unless already at full scale; counters never wrap.
    function automatic logic [CNT_WIDTH-1:0] f_sat_inc(
        input logic [CNT_WIDTH-1:0] v,
        input logic                 en
    );
        return (en && (v != c_CNT_MAX)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] r_cnt_a;
    logic [CNT_WIDTH-1:0] r_cnt_b;
    logic [CNT_WIDTH-1:0] r_cnt_c;
    logic                 r_alarm;
    logic                 r_multi;
    logic                 r_overflow;
    logic                 r_evt_valid;
    logic [2:0]           r_evt_mask;
    logic                 r_evt_multi;

    // ------------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------------
    logic                 w_any_fault;
    logic                 w_event;
    logic                 w_count_en;
    logic [2:0]           w_mask;
    logic                 w_multi;
    logic                 w_load;
    logic [CNT_WIDTH-1:0] w_cnt_a_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_b_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_c_nxt;
    logic                 w_alarm_hit;

    assign w_any_fault = |fault_i;
    assign w_event     = valid_i & w_any_fault;
    // A clear in the same cycle swallows the event completely.
    assign w_count_en  = w_event & ~clr_i;

    // Only bits the voters flagged count towards a replica's mismatch.
    assign w_mask[0] = |((a_i ^ majority_i) & fault_i);
    assign w_mask[1] = |((b_i ^ majority_i) & fault_i);
    assign w_mask[2] = |((c_i ^ majority_i) & fault_i);

    // Two or more replicas wrong is uncorrectable; none wrong despite a
    // flagged bit means the voter inputs are inconsistent.
    assign w_multi = (w_mask[0] & w_mask[1]) | (w_mask[0] & w_mask[2]) |
                     (w_mask[1] & w_mask[2]) | (w_mask == 3'b000);

    // The record slot takes a new event if empty or being drained this edge.
    assign w_load = w_count_en & (~r_evt_valid | evt_ready_i);

    assign w_cnt_a_nxt = clr_i ? '0 : f_sat_inc(r_cnt_a, w_count_en & w_mask[0]);
    assign w_cnt_b_nxt = clr_i ? '0 : f_sat_inc(r_cnt_b, w_count_en & w_mask[1]);
    assign w_cnt_c_nxt = clr_i ? '0 : f_sat_inc(r_cnt_c, w_count_en & w_mask[2]);

    // Alarm is judged on the next counter values so it appears together
    // with the count that triggers it.
    assign w_alarm_hit = (w_cnt_a_nxt >= c_THRESH) | (w_cnt_b_nxt >= c_THRESH) |
                         (w_cnt_c_nxt >= c_THRESH);

    // Counters and sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_cnt_c    <= '0;
            r_alarm    <= 1'b0;
            r_multi    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_cnt_a    <= w_cnt_a_nxt;
            r_cnt_b    <= w_cnt_b_nxt;
            r_cnt_c    <= w_cnt_c_nxt;
            r_alarm    <= clr_i ? 1'b0 : (r_alarm | w_alarm_hit);
            r_multi    <= clr_i ? 1'b0 : (r_multi | (w_count_en & w_multi));
            r_overflow <= clr_i ? 1'b0 :
                          (r_overflow | (w_count_en & r_evt_valid & ~evt_ready_i));
        end
    end

    // Single-entry event record; a clear leaves a pending record in place.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_evt_valid <= 1'b0;
            r_evt_mask  <= 3'b000;
            r_evt_multi <= 1'b0;
        end else begin
            r_evt_valid <= w_load | (r_evt_valid & ~evt_ready_i);
            if (w_load) begin
                r_evt_mask  <= w_mask;
                r_evt_multi <= w_multi;
            end
        end
    end

`ifdef TMR_FAULT_MON_BITIDX_EN
    logic [c_BIT_W-1:0] w_bit_idx;
    logic [c_BIT_W-1:0] r_evt_bit;

    // Priority encoder: scanning downwards leaves the lowest set index.
    always_comb begin
        w_bit_idx = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (fault_i[i]) begin
                w_bit_idx = c_BIT_W'(i);
            end
        end
    end

    // Bit index is captured alongside the rest of the record.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_evt_bit <= '0;
        end else if (w_load) begin
            r_evt_bit <= w_bit_idx;
        end
    end

    assign evt_bit_o = r_evt_bit;
`else
    assign evt_bit_o = '0;
`endif

    assign evt_valid_o = r_evt_valid;
    assign evt_mask_o  = r_evt_mask;
    assign evt_multi_o = r_evt_multi;
    assign cnt_a_o     = r_cnt_a;
    assign cnt_b_o     = r_cnt_b;
    assign cnt_c_o     = r_cnt_c;
    assign alarm_o     = r_alarm;
    assign multi_o     = r_multi;
    assign overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_fault_monitor
// Brief    : Self-checking bench for tmr_fault_monitor: table of directed
//            vectors with hand-computed expectations plus short sequences
//            for idle, saturation and reset-mid-handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_fault_monitor;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int TH = 4;
    localparam int NV = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [DW-1:0] a, b, c, maj, fault;
    logic          clr;
    logic          evt_valid;
    logic          evt_ready;
    logic [2:0]    evt_mask;
    logic          evt_multi;
    logic [4:0]    evt_bit;
    logic [CW-1:0] cnt_a, cnt_b, cnt_c;
    logic          alarm, multi, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tmr_fault_monitor #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .THRESHOLD (TH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid),
        .a_i        (a),
        .b_i        (b),
        .c_i        (c),
        .majority_i (maj),
        .fault_i    (fault),
        .clr_i      (clr),
        .evt_valid_o(evt_valid),
        .evt_ready_i(evt_ready),
        .evt_mask_o (evt_mask),
        .evt_multi_o(evt_multi),
        .evt_bit_o  (evt_bit),
        .cnt_a_o    (cnt_a),
        .cnt_b_o    (cnt_b),
        .cnt_c_o    (cnt_c),
        .alarm_o    (alarm),
        .multi_o    (multi),
        .overflow_o (overflow)
    );

    typedef struct {
        logic          valid;
        logic          clr;
        logic          ready;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [DW-1:0] fault;
        logic          e_ev;
        logic [2:0]    e_mask;
        logic          e_multi;
        logic [4:0]    e_bit;
        logic [CW-1:0] e_ca;
        logic [CW-1:0] e_cb;
        logic [CW-1:0] e_cc;
        logic          e_alarm;
        logic          e_multi_o;
        logic          e_ovf;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic v, input logic cl, input logic rd,
                        input logic [DW-1:0] va, input logic [DW-1:0] vb,
                        input logic [DW-1:0] vc, input logic [DW-1:0] vf,
                        input logic ev, input logic [2:0] mk, input logic mu,
                        input logic [4:0] bi, input logic [CW-1:0] ca,
                        input logic [CW-1:0] cb, input logic [CW-1:0] cc,
                        input logic al, input logic mo, input logic ov);
        vecs[i].valid = v;   vecs[i].clr = cl;     vecs[i].ready = rd;
        vecs[i].a = va;      vecs[i].b = vb;       vecs[i].c = vc;
        vecs[i].fault = vf;  vecs[i].e_ev = ev;    vecs[i].e_mask = mk;
        vecs[i].e_multi = mu;
`ifdef TMR_FAULT_MON_BITIDX_EN
        vecs[i].e_bit = bi;
`else
        vecs[i].e_bit = 5'd0;
`endif
        vecs[i].e_ca = ca;   vecs[i].e_cb = cb;    vecs[i].e_cc = cc;
        vecs[i].e_alarm = al; vecs[i].e_multi_o = mo; vecs[i].e_ovf = ov;
    endtask

    // Drive one cycle of inputs (majority is always zero), let the edge pass.
    task automatic drive(input logic v, input logic cl, input logic rd,
                         input logic [DW-1:0] va, input logic [DW-1:0] vb,
                         input logic [DW-1:0] vc, input logic [DW-1:0] vf);
        valid = v; clr = cl; evt_ready = rd;
        a = va; b = vb; c = vc; maj = '0; fault = vf;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input int idx, input logic [CW-1:0] ca,
                               input logic [CW-1:0] cb, input logic [CW-1:0] cc,
                               input logic al, input logic mo, input logic ov);
        check("cnt_a", idx, 32'(cnt_a), 32'(ca));
        check("cnt_b", idx, 32'(cnt_b), 32'(cb));
        check("cnt_c", idx, 32'(cnt_c), 32'(cc));
        check("alarm", idx, 32'(alarm), 32'(al));
        check("multi_o", idx, 32'(multi), 32'(mo));
        check("overflow", idx, 32'(overflow), 32'(ov));
    endtask

    initial begin
        // valid clr rdy  a        b       c       fault   | ev mask  mu bit ca cb cc al mo ov
        setv( 0, 1, 0, 1, 32'h10,  32'h0,  32'h0,  32'h10,  1, 3'b001, 0, 4, 1, 0, 0, 0, 0, 0);
        setv( 1, 1, 0, 1, 32'h0,   32'h4,  32'h0,  32'h4,   1, 3'b010, 0, 2, 1, 1, 0, 0, 0, 0);
        setv( 2, 1, 0, 1, 32'h1,   32'h0,  32'h2,  32'h3,   1, 3'b101, 1, 0, 2, 1, 1, 0, 1, 0);
        setv( 3, 1, 0, 1, 32'h0,   32'h0,  32'h0,  32'h1,   1, 3'b000, 1, 0, 2, 1, 1, 0, 1, 0);
        setv( 4, 0, 0, 1, 32'h1,   32'h0,  32'h0,  32'h1,   0, 3'b000, 0, 0, 2, 1, 1, 0, 1, 0);
        setv( 5, 1, 1, 1, 32'h10,  32'h0,  32'h0,  32'h10,  0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        setv( 6, 1, 0, 1, 32'h0,   32'h4,  32'h0,  32'h4,   1, 3'b010, 0, 2, 0, 1, 0, 0, 0, 0);
        setv( 7, 1, 0, 1, 32'h0,   32'h4,  32'h0,  32'h4,   1, 3'b010, 0, 2, 0, 2, 0, 0, 0, 0);
        setv( 8, 1, 0, 1, 32'h0,   32'h4,  32'h0,  32'h4,   1, 3'b010, 0, 2, 0, 3, 0, 0, 0, 0);
        setv( 9, 1, 0, 1, 32'h0,   32'h4,  32'h0,  32'h4,   1, 3'b010, 0, 2, 0, 4, 0, 1, 0, 0);
        setv(10, 0, 0, 1, 32'h0,   32'h0,  32'h0,  32'h0,   0, 3'b000, 0, 0, 0, 4, 0, 1, 0, 0);
        setv(11, 1, 0, 0, 32'h10,  32'h0,  32'h0,  32'h10,  1, 3'b001, 0, 4, 1, 4, 0, 1, 0, 0);
        setv(12, 1, 0, 0, 32'h100, 32'h0,  32'h0,  32'h100, 1, 3'b001, 0, 4, 2, 4, 0, 1, 0, 1);
        setv(13, 0, 0, 1, 32'h0,   32'h0,  32'h0,  32'h0,   0, 3'b000, 0, 0, 2, 4, 0, 1, 0, 1);
        setv(14, 1, 0, 0, 32'h10,  32'h0,  32'h0,  32'h10,  1, 3'b001, 0, 4, 3, 4, 0, 1, 0, 1);
        setv(15, 1, 0, 1, 32'h0,   32'h4,  32'h0,  32'h4,   1, 3'b010, 0, 2, 3, 5, 0, 1, 0, 1);
        setv(16, 0, 0, 1, 32'h0,   32'h0,  32'h0,  32'h0,   0, 3'b000, 0, 0, 3, 5, 0, 1, 0, 1);
        setv(17, 1, 0, 0, 32'h0,   32'h0,  32'h8,  32'h8,   1, 3'b100, 0, 3, 3, 5, 1, 1, 0, 1);
        setv(18, 0, 1, 0, 32'h0,   32'h0,  32'h0,  32'h0,   1, 3'b100, 0, 3, 0, 0, 0, 0, 0, 0);
        setv(19, 0, 0, 1, 32'h0,   32'h0,  32'h0,  32'h0,   0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset
        rst = 1'b1; valid = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        a = '0; b = '0; c = '0; maj = '0; fault = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset evt_valid", -1, 32'(evt_valid), 32'd0);
        check("reset evt_mask", -1, 32'(evt_mask), 32'd0);
        check("reset evt_bit", -1, 32'(evt_bit), 32'd0);
        check_flags(-1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Valid with no fault bits is not an event
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h5, 32'h5, 32'h5, 32'h0);
        end
        check("idle evt_valid", -2, 32'(evt_valid), 32'd0);
        check_flags(-2, 0, 0, 0, 0, 0, 0);

        // Directed table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].clr, vecs[i].ready,
                  vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].fault);
            check("evt_valid", i, 32'(evt_valid), 32'(vecs[i].e_ev));
            if (vecs[i].e_ev) begin
                check("evt_mask", i, 32'(evt_mask), 32'(vecs[i].e_mask));
                check("evt_multi", i, 32'(evt_multi), 32'(vecs[i].e_multi));
                check("evt_bit", i, 32'(evt_bit), 32'(vecs[i].e_bit));
            end
            check_flags(i, vecs[i].e_ca, vecs[i].e_cb, vecs[i].e_cc,
                        vecs[i].e_alarm, vecs[i].e_multi_o, vecs[i].e_ovf);
        end

        // Saturation: 300 replica-b faults from zero end at full scale
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h80000000, 32'h0, 32'h80000000);
        end
        check_flags(100, 0, 8'd255, 0, 1, 0, 0);
        check("sat evt_mask", 100, 32'(evt_mask), 32'd2);
`ifdef TMR_FAULT_MON_BITIDX_EN
        check("sat evt_bit", 100, 32'(evt_bit), 32'd31);
`endif

        // Reset while a record is pending drops it
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1, 32'h1);
        check("pre-reset evt_valid", 101, 32'(evt_valid), 32'd1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1, 32'h1);
        rst = 1'b0;
        check("post-reset evt_valid", 102, 32'(evt_valid), 32'd0);
        check_flags(102, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
